// File: rtl/alloc_seq_pkg.sv
// Shared definitions for the allocation-set word: field widths, packing offsets,
// controller state encoding and pack helpers used by the program store and alloc_seq.
package alloc_seq_pkg;

    localparam int unsigned VEC_ID_W       = 4;
    localparam int unsigned STAGE_W        = 3;
    localparam int unsigned DATA_ADDR_W    = 12;
    localparam int unsigned ALLOC_LEN_W    = 10;
    localparam int unsigned REGFILE_ADDR_W = 5;

    localparam int unsigned ALLOCSET_W = STAGE_W + VEC_ID_W + 2*REGFILE_ADDR_W
                                       + ALLOC_LEN_W + 2*DATA_ADDR_W;

    // Field LSB offsets, word packed MSB..LSB as
    // {stage, vec_id, rf_src, rf_dst, len, base_a, base_b}
    localparam int unsigned BASE_B_LSB = 0;
    localparam int unsigned BASE_A_LSB = BASE_B_LSB + DATA_ADDR_W;
    localparam int unsigned LEN_LSB    = BASE_A_LSB + DATA_ADDR_W;
    localparam int unsigned RF_DST_LSB = LEN_LSB + ALLOC_LEN_W;
    localparam int unsigned RF_SRC_LSB = RF_DST_LSB + REGFILE_ADDR_W;
    localparam int unsigned VEC_ID_LSB = RF_SRC_LSB + REGFILE_ADDR_W;
    localparam int unsigned STAGE_LSB  = VEC_ID_LSB + VEC_ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // All-zero alloc-set word, used to tie off unused store entries
    localparam logic [ALLOCSET_W-1:0] GND_BUS = '0;

    function automatic logic [ALLOCSET_W-1:0] pack_allocset(
        input logic [STAGE_W-1:0]        stage,
        input logic [VEC_ID_W-1:0]       vec_id,
        input logic [REGFILE_ADDR_W-1:0] rf_src,
        input logic [REGFILE_ADDR_W-1:0] rf_dst,
        input logic [ALLOC_LEN_W-1:0]    len,
        input logic [DATA_ADDR_W-1:0]    base_a,
        input logic [DATA_ADDR_W-1:0]    base_b
    );
        return {stage, vec_id, rf_src, rf_dst, len, base_a, base_b};
    endfunction

endpackage

// File: rtl/alloc_seq_as_unpack.sv
// Combinational field extraction from a packed alloc-set word.
module as_unpack
    import alloc_seq_pkg::*;
(
    input  logic [ALLOCSET_W-1:0]     word,
    output logic [STAGE_W-1:0]        stage,
    output logic [VEC_ID_W-1:0]       vec_id,
    output logic [REGFILE_ADDR_W-1:0] rf_src,
    output logic [REGFILE_ADDR_W-1:0] rf_dst,
    output logic [ALLOC_LEN_W-1:0]    len,
    output logic [DATA_ADDR_W-1:0]    base_a,
    output logic [DATA_ADDR_W-1:0]    base_b
);

    // Slice each field out of the word at its package-defined offset
    always_comb begin
        stage  = word[STAGE_LSB  +: STAGE_W];
        vec_id = word[VEC_ID_LSB +: VEC_ID_W];
        rf_src = word[RF_SRC_LSB +: REGFILE_ADDR_W];
        rf_dst = word[RF_DST_LSB +: REGFILE_ADDR_W];
        len    = word[LEN_LSB    +: ALLOC_LEN_W];
        base_a = word[BASE_A_LSB +: DATA_ADDR_W];
        base_b = word[BASE_B_LSB +: DATA_ADDR_W];
    end

endmodule

// File: rtl/alloc_seq.sv
// Allocation sequencer: latches one alloc-set word on start, streams len address
// beats to the MAC datapath over valid/ready, then pulses pc_inc.
// Optional build macro ALLOC_SEQ_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module alloc_seq
    import alloc_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ALLOCSET_W-1:0]     as_word,
    output logic                      busy,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [DATA_ADDR_W-1:0]    addr_a,
    output logic [DATA_ADDR_W-1:0]    addr_b,
    output logic [REGFILE_ADDR_W-1:0] rf_src,
    output logic [REGFILE_ADDR_W-1:0] rf_dst,
    output logic [STAGE_W-1:0]        stage,
    output logic [VEC_ID_W-1:0]       vec_id,
    output logic                      beat_last,
    output logic                      pc_inc
`ifdef ALLOC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    logic [STAGE_W-1:0]        f_stage;
    logic [VEC_ID_W-1:0]       f_vec_id;
    logic [REGFILE_ADDR_W-1:0] f_rf_src;
    logic [REGFILE_ADDR_W-1:0] f_rf_dst;
    logic [ALLOC_LEN_W-1:0]    f_len;
    logic [DATA_ADDR_W-1:0]    f_base_a;
    logic [DATA_ADDR_W-1:0]    f_base_b;

    state_t                    state;
    logic [ALLOC_LEN_W-1:0]    idx;
    logic [ALLOC_LEN_W-1:0]    idx_nxt;
    logic [ALLOC_LEN_W-1:0]    len_q;
    logic                      xfer;

    as_unpack u_unpack (
        .word   (as_word),
        .stage  (f_stage),
        .vec_id (f_vec_id),
        .rf_src (f_rf_src),
        .rf_dst (f_rf_dst),
        .len    (f_len),
        .base_a (f_base_a),
        .base_b (f_base_b)
    );

    // Transfer qualifier and next beat index
    always_comb begin
        xfer    = beat_valid && beat_ready;
        idx_nxt = idx + ALLOC_LEN_W'(1);
    end

    // Controller FSM with registered beat outputs.
    // Addresses advance by increment instead of base+idx, which is equivalent
    // mod 2^DATA_ADDR_W and avoids holding the bases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            len_q      <= '0;
            busy       <= 1'b0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            pc_inc     <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            rf_src     <= '0;
            rf_dst     <= '0;
            stage      <= '0;
            vec_id     <= '0;
        end else begin
            pc_inc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stage  <= f_stage;
                        vec_id <= f_vec_id;
                        rf_src <= f_rf_src;
                        rf_dst <= f_rf_dst;
                        addr_a <= f_base_a;
                        addr_b <= f_base_b;
                        len_q  <= f_len;
                        idx    <= '0;
                        busy   <= 1'b1;
                        if (f_len == '0) begin
                            state  <= DONE;
                            pc_inc <= 1'b1;
                        end else begin
                            state      <= RUN;
                            beat_valid <= 1'b1;
                            beat_last  <= (f_len == ALLOC_LEN_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (beat_last) begin
                            state      <= DONE;
                            beat_valid <= 1'b0;
                            beat_last  <= 1'b0;
                            pc_inc     <= 1'b1;
                        end else begin
                            idx       <= idx_nxt;
                            addr_a    <= addr_a + DATA_ADDR_W'(1);
                            addr_b    <= addr_b + DATA_ADDR_W'(1);
                            beat_last <= (idx_nxt == len_q - ALLOC_LEN_W'(1));
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALLOC_SEQ_STALL_CNT_EN
    // Saturating count of stalled RUN cycles, cleared when a start is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && beat_valid && !beat_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alloc_seq.sv
// Scoreboard bench for alloc_seq: stimulus pushes expected beats, a negedge monitor
// checks every cycle against a cycle-level reference of the sequencing rules.
module tb_alloc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [50:0] as_word;
    logic        busy;
    logic        beat_valid;
    logic        beat_ready;
    logic [11:0] addr_a;
    logic [11:0] addr_b;
    logic [4:0]  rf_src;
    logic [4:0]  rf_dst;
    logic [2:0]  stage;
    logic [3:0]  vec_id;
    logic        beat_last;
    logic        pc_inc;
`ifdef ALLOC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    alloc_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .as_word    (as_word),
        .busy       (busy),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .rf_src     (rf_src),
        .rf_dst     (rf_dst),
        .stage      (stage),
        .vec_id     (vec_id),
        .beat_last  (beat_last),
        .pc_inc     (pc_inc)
`ifdef ALLOC_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [2:0]  stg;
        logic [3:0]  vid;
        logic        last;
    } beat_t;

    beat_t       beat_q[$];
    bit          rdy_script[$];
    bit          rand_rdy = 1'b0;

    // reference state for the current cycle
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_pc    = 1'b0;
    logic [15:0] m_stall = '0;
    int          n_xfer  = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ready driver: scripted values first, then random or constant high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_script.size() > 0) beat_ready = rdy_script.pop_front();
            else if (rand_rdy)         beat_ready = ($urandom_range(0, 3) != 0);
            else                       beat_ready = 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        beat_t       b;
        bit          nb, nv, np;
        logic [15:0] ns;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 0; m_valid = 0; m_pc = 0; m_stall = '0;
                beat_q.delete();
            end else begin
                chk("busy", busy, m_busy);
                chk("beat_valid", beat_valid, m_valid);
                chk("pc_inc", pc_inc, m_pc);
`ifdef ALLOC_SEQ_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, m_stall);
`endif
                if (m_valid) begin
                    if (beat_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL beat_q: beat expected but scoreboard empty at %0t", $time);
                    end else begin
                        b = beat_q[0];
                        chk("addr_a", addr_a, b.a);
                        chk("addr_b", addr_b, b.b);
                        chk("rf_src", rf_src, b.src);
                        chk("rf_dst", rf_dst, b.dst);
                        chk("stage", stage, b.stg);
                        chk("vec_id", vec_id, b.vid);
                        chk("beat_last", beat_last, b.last);
                    end
                end
                nb = m_busy; nv = m_valid; np = 0; ns = m_stall;
                if (m_pc) nb = 0;
                if (m_valid && beat_ready && beat_q.size() > 0) begin
                    b = beat_q.pop_front();
                    n_xfer++;
                    if (b.last) begin nv = 0; np = 1; end
                end
                if (m_valid && !beat_ready && ns != 16'hFFFF) ns = ns + 16'd1;
                if (start && !m_busy) begin
                    nb = 1; ns = '0;
                    if (as_word[33:24] == 10'd0) np = 1;
                    else nv = 1;
                end
                m_busy = nb; m_valid = nv; m_pc = np; m_stall = ns;
            end
        end
    end

    // wait for reference idle, pulse start, push expected beats
    task automatic issue(input logic [2:0] stg, input logic [3:0] vid,
                         input logic [4:0] src, input logic [4:0] dst,
                         input logic [9:0] len, input logic [11:0] ba,
                         input logic [11:0] bb);
        beat_t b;
        int    guard = 0;
        while (m_busy && guard < 3000) begin
            @(posedge clk); #2; guard++;
        end
        if (m_busy) begin
            total++; bad++;
            $display("FAIL idle_wait: still busy=%0d, required 0", m_busy);
        end
        as_word = {stg, vid, src, dst, len, ba, bb};
        start   = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            b.a = 12'(ba + i); b.b = 12'(bb + i);
            b.src = src; b.dst = dst; b.stg = stg; b.vid = vid;
            b.last = (i == int'(len) - 1);
            beat_q.push_back(b);
        end
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((m_busy || beat_q.size() > 0) && guard < 3000) begin
            @(posedge clk); #2; guard++;
        end
        total++;
        if (m_busy || beat_q.size() > 0) begin
            bad++;
            $display("FAIL done_wait: busy=%0d pending=%0d, required 0 0", m_busy, beat_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int guard;
        rst = 1'b0; start = 1'b0; as_word = '0; beat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", beat_valid, 0);
        chk("rst_pc", pc_inc, 0);
        chk("rst_addr_a", addr_a, 0);
        rst = 1'b1;
        @(posedge clk); #2;

        // basic run
        issue(3'd5, 4'd9, 5'd3, 5'd17, 10'd4, 12'h010, 12'h200);
        wait_done();

        // asynchronous reset in the middle of a len=8 run, at idx=3
        x0 = n_xfer;
        issue(3'd2, 4'd6, 5'd1, 5'd2, 10'd8, 12'h300, 12'h400);
        guard = 0;
        while (n_xfer - x0 < 3 && guard < 100) begin
            @(posedge clk); #2; guard++;
        end
        chk("pre_rst_xfers", n_xfer - x0, 3);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", beat_valid, 0);
        chk("mid_rst_pc", pc_inc, 0);
        chk("mid_rst_addr_a", addr_a, 0);
        chk("mid_rst_addr_b", addr_b, 0);
        chk("mid_rst_rf", {rf_src, rf_dst}, 0);
        chk("mid_rst_stg_vid", {stage, vec_id}, 0);
        chk("mid_rst_last", beat_last, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        // backpressure: beat 1 stalled two cycles
        rdy_script.push_back(1'b1);
        rdy_script.push_back(1'b0);
        rdy_script.push_back(1'b0);
        issue(3'd1, 4'd3, 5'd7, 5'd8, 10'd3, 12'h0A0, 12'h0B0);
        wait_done();

        // address wrap
        issue(3'd0, 4'd1, 5'd0, 5'd31, 10'd4, 12'hFFE, 12'hFFD);
        wait_done();

        // zero-length allocation
        issue(3'd7, 4'd15, 5'd4, 5'd5, 10'd0, 12'h123, 12'h456);
        wait_done();

        // starts while busy, including during the completion cycle
        issue(3'd4, 4'd2, 5'd9, 5'd10, 10'd5, 12'h050, 12'h060);
        as_word = {3'd6, 4'd7, 5'd11, 5'd12, 10'd7, 12'h777, 12'h888};
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        guard = 0;
        while (!m_pc && guard < 100) begin
            @(posedge clk); #2; guard++;
        end
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done();

        // randomized jobs with random backpressure
        rand_rdy = 1'b1;
        for (int j = 0; j < 30; j++) begin
            issue(3'($urandom), 4'($urandom), 5'($urandom), 5'($urandom),
                  10'($urandom_range(0, 12)), 12'($urandom), 12'($urandom));
            wait_done();
        end

        // maximum length
        rand_rdy = 1'b0;
        issue(3'd3, 4'd4, 5'd5, 5'd6, 10'h3FF, 12'($urandom), 12'hF00);
        wait_done();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
